l2_bank_rr_arbiter: RTL and testbench

L2_BANK_RR_ARBITER -- requirements
Module: l2_bank_rr_arbiter

---
 rtl/l2_bank_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_l2_bank_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter sharing one L2 bank port among several TCDM masters.
// Responses return in order and are routed back through a small FIFO of winner indices.
module l2_bank_rr_arbiter #(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_MASTERS-1:0]                  m_req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  m_add_i,
  input  logic [NB_MASTERS-1:0]                  m_wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  output logic [NB_MASTERS-1:0]                  m_gnt_o,
  output logic [NB_MASTERS-1:0]                  m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                  m_r_rdata_o,
  output logic                                   m_r_opc_o,
  output logic                                   b_req_o,
  output logic [ADDR_WIDTH-1:0]                  b_add_o,
  output logic                                   b_wen_o,
  output logic [DATA_WIDTH-1:0]                  b_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                b_be_o,
  input  logic                                   b_gnt_i,
  input  logic                                   b_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  b_r_rdata_i,
  input  logic                                   b_r_opc_i,
  output logic                                   err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] fifo_r [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] winner_s;
  logic             any_req_s;
  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             pop_s;

  assign full_s    = (cnt_r == CNT_W'(RSP_DEPTH));
  assign empty_s   = (cnt_r == {CNT_W{1'b0}});
  assign any_req_s = |m_req_i;
  assign b_req_o   = any_req_s & (~full_s | b_r_valid_i);
  assign accept_s  = b_req_o & b_gnt_i;
  assign pop_s     = b_r_valid_i & ~empty_s;
  assign err_o     = err_r;

  // Round-robin pick: scanning offsets downward leaves the closest requester at/after rr_ptr.
  always_comb begin
    sum_s    = {(IDX_W+1){1'b0}};
    cand_s   = {IDX_W{1'b0}};
    winner_s = {IDX_W{1'b0}};
    for (int i = NB_MASTERS - 1; i >= 0; i--) begin
      sum_s  = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
      cand_s = (sum_s >= (IDX_W+1)'(NB_MASTERS)) ? IDX_W'(sum_s - (IDX_W+1)'(NB_MASTERS))
                                                 : IDX_W'(sum_s);
      if (m_req_i[cand_s]) begin
        winner_s = cand_s;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Bank-side request fields and one-hot grant/response routing.
  always_comb begin
    m_gnt_o     = {NB_MASTERS{1'b0}};
    m_r_valid_o = {NB_MASTERS{1'b0}};
    m_gnt_o[winner_s]           = accept_s;
    m_r_valid_o[fifo_r[rd_ptr_r]] = pop_s;
    if (any_req_s) begin
      b_add_o   = m_add_i[winner_s];
      b_wen_o   = m_wen_i[winner_s];
      b_wdata_o = m_wdata_i[winner_s];
      b_be_o    = m_be_i[winner_s];
    end else begin
      b_add_o   = {ADDR_WIDTH{1'b0}};
      b_wen_o   = 1'b1;
      b_wdata_o = {DATA_WIDTH{1'b0}};
      b_be_o    = {BE_WIDTH{1'b0}};
    end
    if (b_r_valid_i) begin
      m_r_rdata_o = b_r_rdata_i;
      m_r_opc_o   = b_r_opc_i;
    end else begin
      m_r_rdata_o = {DATA_WIDTH{1'b0}};
      m_r_opc_o   = 1'b0;
    end
  end

  // Round-robin pointer, response FIFO and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_r <= {IDX_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_r[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (accept_s) begin
        rr_ptr_r         <= (winner_s == IDX_W'(NB_MASTERS - 1)) ? {IDX_W{1'b0}}
                                                                 : winner_s + 1'b1;
        fifo_r[wr_ptr_r] <= winner_s;
        wr_ptr_r         <= (wr_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                                : wr_ptr_r + 1'b1;
      end else begin
        rr_ptr_r <= rr_ptr_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                        : rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
      // A response with nothing outstanding is a protocol violation; held until reset.
      err_r <= err_r | (b_r_valid_i & empty_s);
    end
  end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Directed bench for l2_bank_rr_arbiter with hand-computed expectations.
module tb_l2_bank_rr_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        m_req_i;
  logic [1:0][31:0]  m_add_i;
  logic [1:0]        m_wen_i;
  logic [1:0][31:0]  m_wdata_i;
  logic [1:0][3:0]   m_be_i;
  logic [1:0]        m_gnt_o;
  logic [1:0]        m_r_valid_o;
  logic [31:0]       m_r_rdata_o;
  logic              m_r_opc_o;
  logic              b_req_o;
  logic [31:0]       b_add_o;
  logic              b_wen_o;
  logic [31:0]       b_wdata_o;
  logic [3:0]        b_be_o;
  logic              b_gnt_i;
  logic              b_r_valid_i;
  logic [31:0]       b_r_rdata_i;
  logic              b_r_opc_i;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  l2_bank_rr_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
    .m_r_rdata_o(m_r_rdata_o), .m_r_opc_o(m_r_opc_o),
    .b_req_o(b_req_o), .b_add_o(b_add_o), .b_wen_o(b_wen_o),
    .b_wdata_o(b_wdata_o), .b_be_o(b_be_o),
    .b_gnt_i(b_gnt_i), .b_r_valid_i(b_r_valid_i),
    .b_r_rdata_i(b_r_rdata_i), .b_r_opc_i(b_r_opc_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    m_req_i     = 2'b00;
    m_add_i     = '0;
    m_wen_i     = 2'b11;
    m_wdata_i   = '0;
    m_be_i      = '0;
    b_gnt_i     = 1'b0;
    b_r_valid_i = 1'b0;
    b_r_rdata_i = 32'h0;
    b_r_opc_i   = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_b_req", b_req_o, 1'b0);
    chk("rst_gnt", m_gnt_o, 2'b00);
    chk("rst_rvalid", m_r_valid_o, 2'b00);
    chk("rst_err", err_o, 1'b0);
    chk("idle_opc_zero", m_r_opc_o, 1'b0);
    chk("idle_wen", b_wen_o, 1'b1);
    chk("idle_add", b_add_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Write from master 1 passes through unmodified
    m_req_i      = 2'b10;
    m_wen_i      = 2'b01;
    m_add_i[1]   = 32'h1C01_0000;
    m_wdata_i[1] = 32'hA5A5_A5A5;
    m_be_i[1]    = 4'h3;
    m_add_i[0]   = 32'h0000_1234;
    b_gnt_i      = 1'b1;
    #1;
    chk("wr_add", b_add_o, 32'h1C01_0000);
    chk("wr_wdata", b_wdata_o, 32'hA5A5_A5A5);
    chk("wr_be", b_be_o, 4'h3);
    chk("wr_wen", b_wen_o, 1'b0);
    chk("wr_gnt", m_gnt_o, 2'b10);
    tick();
    m_req_i     = 2'b00;
    m_wen_i     = 2'b11;
    b_r_valid_i = 1'b1;
    b_r_rdata_i = 32'h1234_5678;
    b_r_opc_i   = 1'b1;
    #1;
    chk("wr_rsp_valid", m_r_valid_o, 2'b10);
    chk("wr_rsp_data", m_r_rdata_o, 32'h1234_5678);
    chk("wr_rsp_opc", m_r_opc_o, 1'b1);
    tick();
    b_r_opc_i = 1'b0;

    // Both request continuously, responses one cycle behind
    for (int k = 0; k < 4; k++) begin
      m_req_i     = 2'b11;
      b_r_valid_i = (k > 0);
      b_r_rdata_i = 32'h100 + k;
      #1;
      chk("alt_gnt", m_gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_rvalid", m_r_valid_o, (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
      tick();
    end
    m_req_i     = 2'b00;
    b_r_valid_i = 1'b1;
    #1;
    chk("alt_drain", m_r_valid_o, 2'b10);
    tick();

    // Master 1 alone three times, then both: pointer wrapped to 0
    for (int k = 0; k < 4; k++) begin
      m_req_i     = (k < 3) ? 2'b10 : 2'b11;
      b_r_valid_i = (k > 0);
      #1;
      chk("solo_gnt", m_gnt_o, (k < 3) ? 2'b10 : 2'b01);
      chk("solo_rvalid", m_r_valid_o, (k == 0) ? 2'b00 : 2'b10);
      tick();
    end
    m_req_i     = 2'b00;
    b_r_valid_i = 1'b1;
    #1;
    chk("solo_drain", m_r_valid_o, 2'b01);
    tick();

    // Bank stalls: no grants, pointer (now 1) must hold
    b_r_valid_i = 1'b0;
    b_gnt_i     = 1'b0;
    m_req_i     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_breq", b_req_o, 1'b1);
      chk("stall_gnt", m_gnt_o, 2'b00);
      tick();
    end

    // Fill the two-entry tracker, then concurrent pop and push when full
    b_gnt_i = 1'b1;
    #1;
    chk("fill_gnt0", m_gnt_o, 2'b10);
    tick();
    chk("fill_gnt1", m_gnt_o, 2'b01);
    tick();
    chk("full_breq", b_req_o, 1'b0);
    chk("full_gnt", m_gnt_o, 2'b00);
    tick();
    b_r_valid_i = 1'b1;
    b_r_rdata_i = 32'hCAFE_0001;
    #1;
    chk("full_pop", m_r_valid_o, 2'b10);
    chk("full_push_breq", b_req_o, 1'b1);
    chk("full_push_gnt", m_gnt_o, 2'b10);
    tick();
    m_req_i = 2'b00;
    #1;
    chk("drain_a", m_r_valid_o, 2'b01);
    tick();
    chk("drain_b", m_r_valid_o, 2'b10);
    tick();

    // Response with nothing outstanding
    b_r_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("orphan_rvalid", m_r_valid_o, 2'b00);
    chk("orphan_data", m_r_rdata_o, 32'hDEAD_BEEF);
    chk("orphan_err_pre", err_o, 1'b0);
    tick();
    b_r_valid_i = 1'b0;
    chk("orphan_err", err_o, 1'b1);
    tick();
    tick();
    chk("orphan_err_sticky", err_o, 1'b1);
    chk("idle_rdata_zero", m_r_rdata_o, 32'h0);
    rst_ni = 1'b0;
    tick();
    chk("err_cleared", err_o, 1'b0);
    rst_ni = 1'b1;

    // Reset mid-operation discards the outstanding entry
    m_req_i = 2'b01;
    tick();
    m_req_i = 2'b00;
    rst_ni  = 1'b0;
    tick();
    rst_ni      = 1'b1;
    b_r_valid_i = 1'b1;
    #1;
    chk("midrst_rvalid", m_r_valid_o, 2'b00);
    tick();
    b_r_valid_i = 1'b0;
    chk("midrst_err", err_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
